// File: rtl/mem_responder_if.sv
// Data memory bus between the core (master) and mem_responder (slave).
`timescale 1ns/1ps
interface mem_responder_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_read_en;
    logic              mem_write_en;
    logic              mem_ready;
    logic [DWIDTH-1:0] mem_rdata;
    logic              rd_valid;
    logic              rd_err;
    logic              wr_err;

    modport master (
        output mem_addr, mem_wdata, mem_read_en, mem_write_en,
        input  mem_ready, mem_rdata, rd_valid, rd_err, wr_err
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read_en, mem_write_en,
        output mem_ready, mem_rdata, rd_valid, rd_err, wr_err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-array memory responder with LATENCY-stage read pipeline and error flags.
// Optional MEM_STALL_EN: LFSR-driven mem_ready back-pressure.
`timescale 1ns/1ps
module mem_responder #(
    parameter int                DWIDTH    = 32,
    parameter int                DEPTH     = 1024,
    parameter int                LATENCY   = 1,
    parameter logic [DWIDTH-1:0] BASE_ADDR = 32'h0100_0000
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH-1:0]  mem_q [DEPTH];
    logic [DWIDTH-3:0]  woff;
    logic [AW-1:0]      idx;
    logic               misaligned, out_of_range, both_en, bad;
    logic               ready, acc_rd, acc_wr;
    logic               run_q;
    logic               wr_err_q;
    logic               rd_in_vld;
    logic [DWIDTH-1:0]  rd_in_data;
    logic [DWIDTH-1:0]  out_src;
    logic [DWIDTH-1:0]  rdata_q;
    logic [LATENCY-1:0] vld_q, vld_d, err_q, err_d;

    // Word offset: BASE_ADDR is word aligned, so subtracting word parts equals (addr-BASE)>>2
    assign woff         = bus.mem_addr[DWIDTH-1:2] - BASE_ADDR[DWIDTH-1:2];
    assign idx          = woff[AW-1:0];
    assign out_of_range = |woff[DWIDTH-3:AW];
    assign misaligned   = |bus.mem_addr[1:0];
    assign both_en      = bus.mem_read_en & bus.mem_write_en;
    assign bad          = misaligned | out_of_range | both_en;

    assign acc_rd     = ready & bus.mem_read_en;
    assign acc_wr     = ready & bus.mem_write_en;
    assign rd_in_vld  = acc_rd & ~both_en;
    assign rd_in_data = bad ? '0 : mem_q[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

`ifdef MEM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign ready  = run_q & ~lfsr_q[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 8'hA5;
        else      lfsr_q <= lfsr_d;
    end
`else
    assign ready = run_q;
`endif

    // Array is deliberately not reset; contents survive rst
    always_ff @(posedge clk) begin
        if (acc_wr && !bad) mem_q[idx] <= bus.mem_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wr_err_q <= 1'b0;
        else      wr_err_q <= acc_wr & bad;
    end

    always_comb begin
        vld_d    = '0;
        err_d    = '0;
        vld_d[0] = rd_in_vld;
        err_d[0] = rd_in_vld & bad;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            err_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

    // Intermediate data stages only load on valid and need no reset
    generate
        if (LATENCY > 1) begin : g_mid
            logic [DWIDTH-1:0] mid_q [LATENCY-1];
            always_ff @(posedge clk) begin
                if (vld_d[0]) mid_q[0] <= rd_in_data;
                for (int i = 1; i < LATENCY-1; i++) begin
                    if (vld_d[i]) mid_q[i] <= mid_q[i-1];
                end
            end
            assign out_src = mid_q[LATENCY-2];
        end else begin : g_nomid
            assign out_src = rd_in_data;
        end
    endgenerate

    // Output stage holds its last value across idle slots
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    rdata_q <= '0;
        else if (vld_d[LATENCY-1])   rdata_q <= out_src;
    end

    assign bus.mem_ready = ready;
    assign bus.mem_rdata = rdata_q;
    assign bus.rd_valid  = vld_q[LATENCY-1];
    assign bus.rd_err    = err_q[LATENCY-1];
    assign bus.wr_err    = wr_err_q;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's data memory interface: it consumes the address, write data and read/write enables the core drives, and returns read data.
- Holds a word array and a configurable-latency read pipeline, with error signalling for bad requests.
- Sits opposite the core inside the wrapper/testbench and replaces the testbench-driven mem_data_in.

Parameters:
- DWIDTH, 32, data and address width in bits.
- DEPTH, 1024, number of DWIDTH-bit words stored; power of two.
- LATENCY, 1, read latency in cycles from acceptance to rd_valid; legal range 1..4.
- BASE_ADDR, 32'h0100_0000, byte address of word 0.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- mem_addr  input  DWIDTH  byte address from core.
- mem_wdata  input  DWIDTH  write data (core's mem_data_out).
- mem_read_en  input  1  read request.
- mem_write_en  input  1  write request.
- mem_ready  output  1  request accepted this cycle when high.
- mem_rdata  output  DWIDTH  read data (core's mem_data_in).
- rd_valid  output  1  mem_rdata valid this cycle.
- rd_err  output  1  qualifies rd_valid; the response was an error.
- wr_err  output  1  one-cycle pulse; the write accepted on the previous edge was rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_rdata=0, rd_valid=0, rd_err=0, wr_err=0, mem_ready=0.
  - Read pipeline flushed.
  - Array contents are not cleared.
- After reset: mem_ready=1 from the first cycle after rst rises, unless MEM_STALL_EN is defined.
- Acceptance: a request is accepted on a rising edge where mem_ready=1 and (mem_read_en or mem_write_en). Inputs are ignored when not accepted; the core must hold them.
- Index: idx = (mem_addr - BASE_ADDR) >> 2. Arithmetic is unsigned DWIDTH-bit, so addresses below BASE_ADDR wrap to a large offset and fall out of range.
- A request is bad if any of the following holds:
  - mem_addr[1:0] != 0;
  - offset >= DEPTH*4;
  - mem_read_en and mem_write_en are both high.
- Good write: the array word is updated on the acceptance edge. wr_err=0.
- Bad write (including read+write together): no array update. wr_err=1 for exactly the cycle after the acceptance edge. If both enables were high, no read response is generated.
- Read pipeline: LATENCY-stage shift of {valid, err, data}.
  - A read accepted at edge k gives rd_valid=1 with its data during the cycle following edge k+LATENCY-1. For example, LATENCY=1 gives data in the cycle right after acceptance.
  - Data is sampled from the array at the acceptance edge, so it reflects all writes accepted on earlier edges.
- Bad read: rd_valid=1, rd_err=1, mem_rdata=0 at the normal latency slot.
- Idle slot: rd_valid=0, rd_err=0, and mem_rdata holds its last value.
- Back-to-back reads: one accepted per cycle, fully pipelined. Responses return in order, one per cycle.
- Write followed by read to the same address on the next edge: the read returns the new data.
- Reset mid-operation: in-flight reads are discarded; no rd_valid is produced for them after reset.

Optional Feature:
- Macro: MEM_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 at reset and advances every cycle.
  - mem_ready = ~lfsr[0] while the LFSR is running; mem_ready=0 during reset.
  - Requests arriving while mem_ready=0 wait and are accepted on the first edge with mem_ready=1.
  - Latency is counted from acceptance.
- Not defined: no LFSR exists and mem_ready=1 whenever not in reset.

Test Plan:
- Aligned write/read:
  - Stimulus: write 32'hDEADBEEF to BASE_ADDR+8, then read BASE_ADDR+8 on the next cycle.
  - Required: rd_valid=1 with 32'hDEADBEEF and rd_err=0 exactly LATENCY cycles after the read is accepted.
- Pipelined reads:
  - Stimulus: LATENCY=3; preload words 0..3 with 1..4; issue four back-to-back reads.
  - Required: rd_valid high for 4 consecutive cycles starting 3 cycles after the first acceptance; data 1,2,3,4 in order.
- Bad requests:
  - Stimulus: read BASE_ADDR+2 (misaligned); write BASE_ADDR+DEPTH*4 (out of range); one cycle with both enables high.
  - Required: rd_valid=1, rd_err=1, data 0 for the misaligned read. wr_err pulses once for each of the other two. Re-reading word 0 is unchanged.
- Reset mid-flight:
  - Stimulus: LATENCY=4; issue a read; drive rst=0 two cycles later.
  - Required: all outputs are 0 immediately. No rd_valid appears after rst returns to 1, and a value written before reset is still readable.
- Stall handshake (MEM_STALL_EN defined):
  - Stimulus: hold a read request steady.
  - Required: acceptance occurs only on an edge with mem_ready=1. The first mem_ready values after reset match the LFSR sequence from 8'hA5, and the response arrives LATENCY cycles after acceptance.
